// File: rtl/trap_pkg.sv
// trap_pkg: shared FSM states, mcause codes, mie bit indices, CSR addresses and vector-target helper
package trap_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_TRAP,
      S_REDIRECT,
      S_MRET
   } state_t;

   localparam logic [31:0] MCAUSE_EXT   = 32'h8000_000B;
   localparam logic [31:0] MCAUSE_SW    = 32'h8000_0003;
   localparam logic [31:0] MCAUSE_TIMER = 32'h8000_0007;

   localparam int MIE_MEIE = 11;
   localparam int MIE_MSIE = 3;
   localparam int MIE_MTIE = 7;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [1:0] MTVEC_VECTORED = 2'd1;

   // Modes 2 and 3 fall back to direct; the 32-bit add wraps naturally.
   function automatic logic [31:0] trap_target(input logic [31:0] mtvec, input logic [4:0] code);
      logic [31:0] base;
      base = {mtvec[31:2], 2'b00};
      return (mtvec[1:0] == MTVEC_VECTORED) ? base + {25'd0, code, 2'b00} : base;
   endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: fixed-priority (ext > sw > timer) interrupt select and mcause generation
//   i_req   : enabled pending requests {ext, sw, timer}
//   o_valid : any request present
//   o_cause : mcause of the winning request (0 when none)
module irq_priority_encoder
   import trap_pkg::*;
(
   input  logic [2:0]  i_req,
   output logic        o_valid,
   output logic [31:0] o_cause
);

   always_comb begin
      o_valid = |i_req;
      o_cause = i_req[2] ? MCAUSE_EXT :
                i_req[1] ? MCAUSE_SW  :
                i_req[0] ? MCAUSE_TIMER : '0;
   end

endmodule

// File: rtl/interrupt_trap_controller.sv
// interrupt_trap_controller: machine-mode interrupt entry and MRET sequencing for an in-order pipeline
//   clk, reset                       : clock, synchronous active-high reset
//   irq_ext/irq_sw/irq_timer         : level interrupt requests
//   mstatus_mie, mie, mtvec, mepc_in : CSR state feeding the decision and redirect target
//   resume_valid, resume_pc          : oldest uncommitted PC, becomes mepc on trap entry
//   is_mret                          : MRET resolving in execute
//   stall, flush                     : pipeline control
//   redirect_valid, redirect_pc      : fetch redirect
//   csr_trap_we, csr_mepc, csr_mcause: one-cycle trap-entry CSR write
//   csr_mret_restore                 : restore mstatus.MIE from MPIE
//   busy                             : controller not idle
module interrupt_trap_controller
   import trap_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        irq_ext,
   input  logic        irq_sw,
   input  logic        irq_timer,
   input  logic        mstatus_mie,
   input  logic [31:0] mie,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc_in,
   input  logic        resume_valid,
   input  logic [31:0] resume_pc,
   input  logic        is_mret,
   output logic        stall,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        csr_trap_we,
   output logic [31:0] csr_mepc,
   output logic [31:0] csr_mcause,
   output logic        csr_mret_restore,
   output logic        busy
);

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_pend;
   logic [31:0] r_cause;
   logic [31:0] r_epc;
   logic [2:0]  w_req;
   logic        w_valid;
   logic [31:0] w_cause;
   logic        w_take;
   logic        w_unused_mie;

   assign w_req        = r_pend & {mie[MIE_MEIE], mie[MIE_MSIE], mie[MIE_MTIE]};
   assign w_take       = mstatus_mie & w_valid;
   assign w_unused_mie = &{1'b0, mie};

   irq_priority_encoder u_prio (
      .i_req   (w_req),
      .o_valid (w_valid),
      .o_cause (w_cause)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pend  <= '0;
         r_cause <= '0;
         r_epc   <= '0;
      end else begin
         r_state <= w_next;
         r_pend  <= {irq_ext, irq_sw, irq_timer};
         if (r_state == S_IDLE && !is_mret && w_take) r_cause <= w_cause;
         if (r_state == S_WAIT && resume_valid) r_epc <= resume_pc;
      end
   end

   // Outputs are gated by reset so nothing escapes while a discarded trap is being flushed.
   always_comb begin
      w_next           = r_state;
      stall            = 1'b0;
      flush            = 1'b0;
      redirect_valid   = 1'b0;
      redirect_pc      = '0;
      csr_trap_we      = 1'b0;
      csr_mepc         = '0;
      csr_mcause       = '0;
      csr_mret_restore = 1'b0;
      busy             = 1'b0;
      if (!reset) begin
         busy = (r_state != S_IDLE);
         case (r_state)
            S_IDLE: w_next = is_mret ? S_MRET : w_take ? S_WAIT : S_IDLE;
            S_WAIT: begin
               stall  = 1'b1;
               w_next = resume_valid ? S_TRAP : S_WAIT;
            end
            S_TRAP: begin
               stall       = 1'b1;
               csr_trap_we = 1'b1;
               csr_mepc    = r_epc;
               csr_mcause  = r_cause;
               w_next      = S_REDIRECT;
            end
            S_REDIRECT: begin
               redirect_valid = 1'b1;
               flush          = 1'b1;
               redirect_pc    = trap_target(mtvec, r_cause[4:0]);
               w_next         = S_IDLE;
            end
            S_MRET: begin
               csr_mret_restore = 1'b1;
               flush            = 1'b1;
               redirect_valid   = 1'b1;
               redirect_pc      = mepc_in;
               w_next           = S_IDLE;
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_trap_controller.sv
// tb_interrupt_trap_controller: scoreboard bench for interrupt_trap_controller
module tb_interrupt_trap_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        irq_ext = 1'b0, irq_sw = 1'b0, irq_timer = 1'b0;
   logic        mstatus_mie = 1'b0;
   logic [31:0] mie = '0, mtvec = '0, mepc_in = '0, resume_pc = '0;
   logic        resume_valid = 1'b0, is_mret = 1'b0;
   logic        stall, flush, redirect_valid, csr_trap_we, csr_mret_restore, busy;
   logic [31:0] redirect_pc, csr_mepc, csr_mcause;
   logic [101:0] all_out;

   typedef struct {
      bit          is_mret;
      logic [31:0] mepc;
      logic [31:0] mcause;
      logic [31:0] pc;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   bit          trap_seen = 0;
   logic [31:0] seen_mepc, seen_mcause;
   int          checks = 0;
   int          errors = 0;

   assign all_out = {stall, flush, redirect_valid, redirect_pc, csr_trap_we,
                     csr_mepc, csr_mcause, csr_mret_restore, busy};

   interrupt_trap_controller dut (
      .clk              (clk),
      .reset            (reset),
      .irq_ext          (irq_ext),
      .irq_sw           (irq_sw),
      .irq_timer        (irq_timer),
      .mstatus_mie      (mstatus_mie),
      .mie              (mie),
      .mtvec            (mtvec),
      .mepc_in          (mepc_in),
      .resume_valid     (resume_valid),
      .resume_pc        (resume_pc),
      .is_mret          (is_mret),
      .stall            (stall),
      .flush            (flush),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .csr_trap_we      (csr_trap_we),
      .csr_mepc         (csr_mepc),
      .csr_mcause       (csr_mcause),
      .csr_mret_restore (csr_mret_restore),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Scoreboard: trap writes and redirects are matched against the expected queue.
   always @(negedge clk) begin
      if (reset) trap_seen = 0;
      else begin
         if (csr_trap_we) begin
            checks++;
            if (q.size() == 0 || q[0].is_mret || trap_seen) begin
               errors++;
               $display("FAIL trap_we_unexpected got mcause=%h mepc=%h required none", csr_mcause, csr_mepc);
            end else begin
               trap_seen   = 1;
               seen_mepc   = csr_mepc;
               seen_mcause = csr_mcause;
            end
         end
         if (redirect_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL redirect_unexpected got pc=%h required none", redirect_pc);
            end else begin
               mon_e = q.pop_front();
               checks++;
               if (redirect_pc !== mon_e.pc) begin
                  errors++;
                  $display("FAIL redirect_pc got %h required %h", redirect_pc, mon_e.pc);
               end
               checks++;
               if ({flush, stall, csr_mret_restore} !== {1'b1, 1'b0, mon_e.is_mret}) begin
                  errors++;
                  $display("FAIL redirect_ctl got flush/stall/restore=%b required %b",
                           {flush, stall, csr_mret_restore}, {1'b1, 1'b0, mon_e.is_mret});
               end
               checks++;
               if (mon_e.is_mret) begin
                  if (trap_seen) begin
                     errors++;
                     $display("FAIL mret_trap_we got trap write before MRET required none");
                  end
               end else if (!trap_seen || seen_mepc !== mon_e.mepc || seen_mcause !== mon_e.mcause) begin
                  errors++;
                  $display("FAIL trap_csr got seen=%0d mepc=%h mcause=%h required mepc=%h mcause=%h",
                           trap_seen, seen_mepc, seen_mcause, mon_e.mepc, mon_e.mcause);
               end
               trap_seen = 0;
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_redirect(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         n++;
         if (redirect_valid) return;
      end
      checks++;
      errors++;
      $display("FAIL redirect_timeout got no redirect required one within 40 cycles");
   endtask

   task automatic test_reset();
      repeat (2) step();
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h required 0", all_out);
      end
      reset = 1'b0;
      step();
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL post_reset_outputs got %h required 0", all_out);
      end
   endtask

   task automatic test_ext_basic();
      int n;
      mstatus_mie = 1'b1; mie = 32'h800; mtvec = 32'h2000;
      resume_valid = 1'b1; resume_pc = 32'h100;
      q.push_back('{1'b0, 32'h100, 32'h8000_000B, 32'h2000});
      irq_ext = 1'b1;
      step();
      irq_ext = 1'b0;
      wait_redirect(n);
      checks++;
      if (n + 1 != 4) begin
         errors++;
         $display("FAIL trap_latency got %0d required 4", n + 1);
      end
      step();
      checks++;
      if (busy !== 1'b0 || q.size() != 0) begin
         errors++;
         $display("FAIL ext_idle got busy=%b pending=%0d required 0 0", busy, q.size());
      end
   endtask

   task automatic test_wait_stall();
      int n;
      mtvec = 32'h3002; mie = 32'h8; resume_valid = 1'b0; resume_pc = 32'h344;
      q.push_back('{1'b0, 32'h344, 32'h8000_0003, 32'h3000});
      irq_sw = 1'b1;
      step();
      irq_sw = 1'b0;
      step();
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if ({stall, busy, redirect_valid, csr_trap_we} !== 4'b1100) begin
            errors++;
            $display("FAIL wait_hold got stall/busy/redir/we=%b required 1100",
                     {stall, busy, redirect_valid, csr_trap_we});
         end
      end
      resume_valid = 1'b1;
      wait_redirect(n);
      checks++;
      if (n != 2) begin
         errors++;
         $display("FAIL resume_latency got %0d required 2", n);
      end
      step();
   endtask

   task automatic test_vectored(input logic [31:0] vec, input logic [31:0] en, input logic [2:0] irqs,
                                input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] target);
      int n;
      mtvec = vec; mie = en; resume_pc = pc;
      q.push_back('{1'b0, pc, cause, target});
      {irq_ext, irq_sw, irq_timer} = irqs;
      step();
      {irq_ext, irq_sw, irq_timer} = 3'b000;
      wait_redirect(n);
      step();
   endtask

   task automatic test_priority();
      int n;
      mtvec = 32'h4000; mie = 32'h888; resume_pc = 32'h700; mepc_in = 32'h200;
      q.push_back('{1'b0, 32'h700, 32'h8000_000B, 32'h4000});
      q.push_back('{1'b1, 32'h0, 32'h0, 32'h200});
      q.push_back('{1'b0, 32'h700, 32'h8000_0003, 32'h4000});
      {irq_ext, irq_sw, irq_timer} = 3'b111;
      wait_redirect(n);
      irq_ext = 1'b0;
      is_mret = 1'b1;
      wait_redirect(n);
      is_mret = 1'b0;
      wait_redirect(n);
      {irq_sw, irq_timer} = 2'b00;
      repeat (2) step();
      checks++;
      if (busy !== 1'b0 || q.size() != 0) begin
         errors++;
         $display("FAIL priority_drain got busy=%b pending=%0d required 0 0", busy, q.size());
      end
   endtask

   task automatic test_mret_take();
      int n;
      mtvec = 32'h4000; mie = 32'h800; mepc_in = 32'h5A0; resume_pc = 32'h600;
      q.push_back('{1'b1, 32'h0, 32'h0, 32'h5A0});
      q.push_back('{1'b0, 32'h600, 32'h8000_000B, 32'h4000});
      irq_ext = 1'b1;
      step();
      is_mret = 1'b1;
      wait_redirect(n);
      checks++;
      if (n != 1 || csr_mret_restore !== 1'b1) begin
         errors++;
         $display("FAIL mret_wins got n=%0d restore=%b required 1 1", n, csr_mret_restore);
      end
      is_mret = 1'b0;
      wait_redirect(n);
      irq_ext = 1'b0;
      repeat (2) step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL mret_take_drain got pending=%0d required 0", q.size());
      end
   endtask

   task automatic test_masked();
      for (int c = 0; c < 2; c++) begin
         mstatus_mie = (c == 1);
         mie = (c == 0) ? 32'h888 : 32'h008;
         {irq_ext, irq_sw, irq_timer} = (c == 0) ? 3'b111 : 3'b101;
         for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({stall, redirect_valid, busy} !== 3'b000) begin
               errors++;
               $display("FAIL masked_%0d got stall/redir/busy=%b required 000", c, {stall, redirect_valid, busy});
            end
         end
         {irq_ext, irq_sw, irq_timer} = 3'b000;
         repeat (2) step();
      end
      mstatus_mie = 1'b1;
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 2; c++) begin
         mie = 32'h800; mtvec = 32'h4000; resume_pc = 32'h900;
         resume_valid = (c == 1);
         if (c == 1) q.push_back('{1'b0, 32'h900, 32'h8000_000B, 32'h4000});
         irq_ext = 1'b1;
         step();
         irq_ext = 1'b0;
         step();
         if (c == 1) step();
         checks++;
         if ((c == 0 && {stall, busy, csr_trap_we} !== 3'b110) || (c == 1 && csr_trap_we !== 1'b1)) begin
            errors++;
            $display("FAIL reset_setup_%0d got stall/busy/we=%b required %s", c,
                     {stall, busy, csr_trap_we}, (c == 0) ? "110" : "we=1");
         end
         reset = 1'b1;
         q.delete();
         step();
         checks++;
         if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_%0d got %h required 0", c, all_out);
         end
         reset = 1'b0;
         resume_valid = 1'b1;
         for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (all_out !== '0) begin
               errors++;
               $display("FAIL reset_after_%0d got %h required 0", c, all_out);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ext_basic();
      test_wait_stall();
      test_vectored(32'h0000_1001, 32'h80, 3'b001, 32'h400, 32'h8000_0007, 32'h0000_101C);
      test_vectored(32'hFFFF_FFFD, 32'h800, 3'b100, 32'hFFFF_FFF0, 32'h8000_000B, 32'h0000_0028);
      test_priority();
      test_mret_take();
      test_masked();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
